// File: rtl/cpu_defs.sv
// Shared fetch-side types and constants for the fetch PC sequencer.
package cpu_defs;

    localparam int unsigned XLEN = 32;

    typedef logic [XLEN-1:0] virt_t;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        WAIT_DS = 2'd1
    } fetch_state_t;

    localparam virt_t RESET_PC_DEFAULT = 32'hbfc0_0000;
    localparam virt_t INSN_BYTES       = 32'd4;

    // One-hot record of which source moved the fetch PC this cycle.
    typedef struct packed {
        logic flush;
        logic corr;
        logic pred;
        logic seq;
    } redir_src_t;

    // Address of the instruction following pc (wraps mod 2^32).
    function automatic virt_t pc_plus4(input virt_t pc);
        return pc + INSN_BYTES;
    endfunction

endpackage

// File: rtl/fetch_redirect_arb.sv
// Combinational next-fetch-PC arbiter: flush > correction > prediction > sequential.
module fetch_redirect_arb
    import cpu_defs::*;
(
    input  virt_t        pc_q,
    input  logic         fire,
    input  fetch_state_t state_q,
    input  virt_t        held_target,
    input  virt_t        held_ds,
    input  logic         flush_valid,
    input  virt_t        flush_target,
    input  logic         is_correction,
    input  logic         corr_pend,
    input  virt_t        correct_target,
    input  logic         pred_valid,
    input  logic         pred_taken,
    input  virt_t        pred_pc,
    input  virt_t        pred_target,
    output virt_t        next_pc,
    output redir_src_t   src,
    output logic         enter_wait_ds,
    output logic         kill
);

    virt_t ds;
    logic  pred_act;
    logic  pred_now;
    logic  pred_wait;
    logic  wds_fire;

    // A taken prediction acts only in RUN and never while the BPU is correcting.
    assign ds        = pc_plus4(pred_pc);
    assign pred_act  = pred_valid && pred_taken && !is_correction && (state_q == RUN);
    // Redirect now if the delay slot fires this cycle or has already been accepted.
    assign pred_now  = pred_act && ((pc_q == ds) ? fire : (pc_q != pred_pc));
    // Otherwise the delay slot (or the branch itself) is still ahead of us.
    assign pred_wait = pred_act && !pred_now;
    assign wds_fire  = (state_q == WAIT_DS) && fire && (pc_q == held_ds);

    // Priority select of the next fetch address.
    always_comb begin
        next_pc       = pc_q;
        src           = '0;
        enter_wait_ds = 1'b0;
        kill          = 1'b0;
        if (flush_valid) begin
            next_pc   = flush_target;
            src.flush = 1'b1;
        end else if (is_correction && !corr_pend) begin
            next_pc  = correct_target;
            src.corr = 1'b1;
        end else if (pred_now) begin
            next_pc  = pred_target;
            src.pred = 1'b1;
            kill     = (pc_q != ds);
        end else if (wds_fire) begin
            next_pc  = held_target;
            src.pred = 1'b1;
        end else begin
            enter_wait_ds = pred_wait;
            if (fire) begin
                next_pc = pc_plus4(pc_q);
                src.seq = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch-address sequencer driving the I-cache request handshake.
// Optional perf counters enabled by defining FETCH_PC_PERF_EN.
module fetch_pc_gen
    import cpu_defs::*;
#(
    parameter virt_t RESET_PC = RESET_PC_DEFAULT
) (
    input  logic  clk,
    input  logic  resetn,
    input  logic  flush_valid,
    input  virt_t flush_target,
    input  logic  is_correction,
    input  virt_t correct_target,
    output logic  correct_finish,
    input  logic  pred_valid,
    input  logic  pred_taken,
    input  virt_t pred_pc,
    input  virt_t pred_target,
    output logic  fetch_valid,
    input  logic  fetch_ready,
    output virt_t fetch_pc,
    output logic  ifq_kill
`ifdef FETCH_PC_PERF_EN
   ,output virt_t perf_redirects,
    output virt_t perf_kills
`endif
);

    fetch_state_t state_q, state_d;
    virt_t        pc_q;
    virt_t        held_target_q, held_target_d;
    virt_t        held_ds_q, held_ds_d;
    logic         corr_pend_q, corr_pend_d;

    virt_t        next_pc;
    redir_src_t   src;
    logic         enter_wait_ds;
    logic         kill_c;
    logic         fire;
    logic         pc_en;

    assign fire           = fetch_valid && fetch_ready;
    assign fetch_pc       = pc_q;
    assign correct_finish = fire && corr_pend_q;
    assign pc_en          = src.flush || src.corr || src.pred || src.seq || enter_wait_ds;

    fetch_redirect_arb u_arb (
        .pc_q          (pc_q),
        .fire          (fire),
        .state_q       (state_q),
        .held_target   (held_target_q),
        .held_ds       (held_ds_q),
        .flush_valid   (flush_valid),
        .flush_target  (flush_target),
        .is_correction (is_correction),
        .corr_pend     (corr_pend_q),
        .correct_target(correct_target),
        .pred_valid    (pred_valid),
        .pred_taken    (pred_taken),
        .pred_pc       (pred_pc),
        .pred_target   (pred_target),
        .next_pc       (next_pc),
        .src           (src),
        .enter_wait_ds (enter_wait_ds),
        .kill          (kill_c)
    );

    // Next-state for the delay-slot FSM, held prediction and correction tracking.
    always_comb begin
        state_d       = state_q;
        held_target_d = held_target_q;
        held_ds_d     = held_ds_q;
        corr_pend_d   = corr_pend_q;
        if (src.flush || src.corr) begin
            state_d       = RUN;
            held_target_d = '0;
            held_ds_d     = '0;
            corr_pend_d   = src.corr;
        end else begin
            if (correct_finish) begin
                corr_pend_d = 1'b0;
            end
            if (src.pred) begin
                state_d = RUN;
            end else if (enter_wait_ds) begin
                state_d       = WAIT_DS;
                held_target_d = pred_target;
                held_ds_d     = pc_plus4(pred_pc);
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            held_target_q <= '0;
            held_ds_q     <= '0;
            corr_pend_q   <= 1'b0;
            fetch_valid   <= 1'b0;
            ifq_kill      <= 1'b0;
        end else begin
            state_q       <= state_d;
            held_target_q <= held_target_d;
            held_ds_q     <= held_ds_d;
            corr_pend_q   <= corr_pend_d;
            fetch_valid   <= 1'b1;
            ifq_kill      <= kill_c;
            if (pc_en) begin
                pc_q <= next_pc;
            end
        end
    end

`ifdef FETCH_PC_PERF_EN
    // Saturating counts of prediction redirects and IF-queue kills.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_redirects <= '0;
            perf_kills     <= '0;
        end else begin
            if (src.pred && (perf_redirects != '1)) begin
                perf_redirects <= perf_redirects + 32'd1;
            end
            if (kill_c && (perf_kills != '1)) begin
                perf_kills <= perf_kills + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed self-checking bench for fetch_pc_gen.
module tb_fetch_pc_gen;
    import cpu_defs::*;

    logic        clk;
    logic        resetn;
    logic        flush_valid;
    logic [31:0] flush_target;
    logic        is_correction;
    logic [31:0] correct_target;
    logic        correct_finish;
    logic        pred_valid;
    logic        pred_taken;
    logic [31:0] pred_pc;
    logic [31:0] pred_target;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_pc;
    logic        ifq_kill;

    int n_cmp = 0;
    int n_err = 0;

    fetch_pc_gen dut (
        .clk           (clk),
        .resetn        (resetn),
        .flush_valid   (flush_valid),
        .flush_target  (flush_target),
        .is_correction (is_correction),
        .correct_target(correct_target),
        .correct_finish(correct_finish),
        .pred_valid    (pred_valid),
        .pred_taken    (pred_taken),
        .pred_pc       (pred_pc),
        .pred_target   (pred_target),
        .fetch_valid   (fetch_valid),
        .fetch_ready   (fetch_ready),
        .fetch_pc      (fetch_pc),
        .ifq_kill      (ifq_kill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_events();
        flush_valid   = 1'b0;
        is_correction = 1'b0;
        pred_valid    = 1'b0;
        pred_taken    = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn         = 1'b0;
        fetch_ready    = 1'b1;
        flush_target   = '0;
        correct_target = '0;
        pred_pc        = '0;
        pred_target    = '0;
        clear_events();

        // Reset held
        step();
        chk("rst_valid", 32'(fetch_valid), 32'd0);
        chk("rst_pc", fetch_pc, 32'hbfc0_0000);
        chk("rst_kill", 32'(ifq_kill), 32'd0);
        chk("rst_cfin", 32'(correct_finish), 32'd0);
        step();
        chk("rst_valid2", 32'(fetch_valid), 32'd0);

        // Release and sequential fetch
        resetn = 1'b1;
        step();
        chk("seq_valid", 32'(fetch_valid), 32'd1);
        chk("seq_pc0", fetch_pc, 32'hbfc0_0000);
        step();
        chk("seq_pc1", fetch_pc, 32'hbfc0_0004);
        step();
        chk("seq_pc2", fetch_pc, 32'hbfc0_0008);
        step();
        step();
        step();
        chk("seq_pc5", fetch_pc, 32'hbfc0_0014);

        // Prediction while delay slot stalled -> WAIT_DS
        fetch_ready = 1'b0;
        pred_valid  = 1'b1;
        pred_taken  = 1'b1;
        pred_pc     = 32'hbfc0_0010;
        pred_target = 32'hbfc0_0100;
        step();
        clear_events();
        chk("wds_hold0", fetch_pc, 32'hbfc0_0014);
        chk("wds_state", 32'(dut.state_q), 32'(WAIT_DS));
        step();
        chk("wds_hold1", fetch_pc, 32'hbfc0_0014);
        step();
        chk("wds_hold2", fetch_pc, 32'hbfc0_0014);
        fetch_ready = 1'b1;
        step();
        chk("wds_target", fetch_pc, 32'hbfc0_0100);
        chk("wds_nokill", 32'(ifq_kill), 32'd0);
        chk("wds_run", 32'(dut.state_q), 32'(RUN));

        // Late prediction -> redirect with kill
        flush_valid  = 1'b1;
        flush_target = 32'hbfc0_001c;
        step();
        clear_events();
        chk("late_pc0", fetch_pc, 32'hbfc0_001c);
        chk("flush_nokill", 32'(ifq_kill), 32'd0);
        pred_valid  = 1'b1;
        pred_taken  = 1'b1;
        pred_pc     = 32'hbfc0_0010;
        pred_target = 32'hbfc0_0100;
        step();
        clear_events();
        chk("late_target", fetch_pc, 32'hbfc0_0100);
        chk("late_kill", 32'(ifq_kill), 32'd1);
        step();
        chk("late_seq", fetch_pc, 32'hbfc0_0104);
        chk("late_kill_off", 32'(ifq_kill), 32'd0);

        // Correction with stalled I-cache; prediction in the window is ignored
        is_correction  = 1'b1;
        correct_target = 32'h8000_1000;
        fetch_ready    = 1'b0;
        step();
        chk("corr_pc0", fetch_pc, 32'h8000_1000);
        chk("corr_cfin0", 32'(correct_finish), 32'd0);
        chk("corr_pend", 32'(dut.corr_pend_q), 32'd1);
        pred_valid  = 1'b1;
        pred_taken  = 1'b1;
        pred_pc     = 32'h8000_0ffc;
        pred_target = 32'hdead_0000;
        step();
        pred_valid = 1'b0;
        pred_taken = 1'b0;
        chk("corr_pc1", fetch_pc, 32'h8000_1000);
        chk("corr_cfin1", 32'(correct_finish), 32'd0);
        fetch_ready = 1'b1;
        #1;
        chk("corr_cfin_fire", 32'(correct_finish), 32'd1);
        step();
        is_correction = 1'b0;
        #1;
        chk("corr_after", fetch_pc, 32'h8000_1004);
        chk("corr_cfin_off", 32'(correct_finish), 32'd0);

        // Flush beats correction and prediction in the same cycle
        flush_valid    = 1'b1;
        flush_target   = 32'hbfc0_0380;
        is_correction  = 1'b1;
        correct_target = 32'h8000_2000;
        pred_valid     = 1'b1;
        pred_taken     = 1'b1;
        pred_pc        = 32'h8000_1000;
        pred_target    = 32'hdead_0000;
        step();
        clear_events();
        chk("prio_pc", fetch_pc, 32'hbfc0_0380);
        chk("prio_corr_pend", 32'(dut.corr_pend_q), 32'd0);
        chk("prio_state", 32'(dut.state_q), 32'(RUN));
        #1;
        chk("prio_cfin", 32'(correct_finish), 32'd0);
        step();
        chk("prio_seq", fetch_pc, 32'hbfc0_0384);

        // Wrap at top of address space
        flush_valid  = 1'b1;
        flush_target = 32'hffff_fffc;
        step();
        clear_events();
        chk("wrap_pc0", fetch_pc, 32'hffff_fffc);
        step();
        chk("wrap_pc1", fetch_pc, 32'h0000_0000);

        // Async reset in the middle of WAIT_DS
        fetch_ready = 1'b0;
        pred_valid  = 1'b1;
        pred_taken  = 1'b1;
        pred_pc     = 32'hffff_fffc;
        pred_target = 32'h0000_0040;
        step();
        clear_events();
        chk("ares_pre_pc", fetch_pc, 32'h0000_0000);
        chk("ares_pre_state", 32'(dut.state_q), 32'(WAIT_DS));
        #2;
        resetn = 1'b0;
        #1;
        chk("ares_pc", fetch_pc, 32'hbfc0_0000);
        chk("ares_state", 32'(dut.state_q), 32'(RUN));
        chk("ares_valid", 32'(fetch_valid), 32'd0);
        #1;
        resetn = 1'b1;
        step();
        chk("ares_rel_valid", 32'(fetch_valid), 32'd1);
        chk("ares_rel_pc", fetch_pc, 32'hbfc0_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
